// File: rtl/pdm_cic_decimator_if.sv
// PCM packet stream leaving pdm_cic_decimator: valid/ready beats carrying a channel index
// and start/end-of-packet markers.
interface pdm_cic_decimator_if #(
  parameter int unsigned OUT_WIDTH = 19
);
  logic signed [OUT_WIDTH-1:0] out_data;
  logic [3:0]                  out_channel;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sop;
  logic                        out_eop;

  modport master (
    output out_data,
    output out_channel,
    output out_valid,
    input  out_ready,
    output out_sop,
    output out_eop
  );

  modport slave (
    input  out_data,
    input  out_channel,
    input  out_valid,
    output out_ready,
    input  out_sop,
    input  out_eop
  );
endinterface

// File: rtl/pdm_cic_decimator.sv
// Multi-channel 4th-order CIC decimator: parallel PDM integration, serial PCM packet output.
// Define PDM_CIC_OVERRUN_CNT_EN to add the saturating overrun_count output.
module pdm_cic_decimator #(
  parameter int unsigned NUM_MICS  = 9,
  parameter int unsigned DEC_LOG2  = 6,
  parameter int unsigned OUT_WIDTH = 19
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_MICS-1:0] pdm,
  input  logic                pdm_en,
  pdm_cic_decimator_if.master pcm,
`ifdef PDM_CIC_OVERRUN_CNT_EN
  output logic [15:0]         overrun_count,
`endif
  output logic                overrun
);
  localparam int unsigned W     = 2 + 4 * DEC_LOG2;
  localparam int unsigned Shift = W - OUT_WIDTH;

  typedef logic signed [W-1:0] acc_t;
  typedef enum logic [0:0] {StIdle, StSend} state_e;

  acc_t                        integ_q [NUM_MICS][4];
  acc_t                        integ_d [NUM_MICS][4];
  acc_t                        dly_q   [NUM_MICS][4];
  acc_t                        dly_d   [NUM_MICS][4];
  logic signed [OUT_WIDTH-1:0] frame_q [NUM_MICS];
  logic signed [OUT_WIDTH-1:0] frame_d [NUM_MICS];
  logic [DEC_LOG2-1:0]         dec_cnt_q;
  logic                        tick_q;
  state_e                      state_q, state_d;
  logic [3:0]                  chan_q, chan_d;
  logic                        accept, last;

  always_comb begin
    acc_t sum;
    acc_t diff;
    sum  = '0;
    diff = '0;
    for (int ch = 0; ch < NUM_MICS; ch++) begin
      // Bit 1 -> +1, bit 0 -> -1, sign-extended to W
      sum = {{(W-1){~pdm[ch]}}, 1'b1};
      for (int s = 0; s < 4; s++) begin
        sum = integ_q[ch][s] + sum;
        integ_d[ch][s] = sum;
      end
      diff = integ_q[ch][3];
      for (int s = 0; s < 4; s++) begin
        dly_d[ch][s] = diff;
        diff = diff - dly_q[ch][s];
      end
      frame_d[ch] = OUT_WIDTH'(diff >>> Shift);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_MICS; ch++) begin
        for (int s = 0; s < 4; s++) begin
          integ_q[ch][s] <= '0;
          dly_q[ch][s]   <= '0;
        end
        frame_q[ch] <= '0;
      end
      dec_cnt_q <= '0;
      tick_q    <= 1'b0;
    end else begin
      if (pdm_en) begin
        integ_q   <= integ_d;
        dec_cnt_q <= dec_cnt_q + DEC_LOG2'(1);
      end
      tick_q <= pdm_en & (&dec_cnt_q);
      // Combs sample integrator 4 after it has absorbed the R-th strobe
      if (tick_q) begin
        dly_q   <= dly_d;
        frame_q <= frame_d;
      end
    end
  end

  assign accept = (state_q == StSend) && pcm.out_ready;
  assign last   = (chan_q == 4'(NUM_MICS - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
    end
  end

  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    overrun = 1'b0;
    if (tick_q) begin
      state_d = StSend;
      chan_d  = '0;
      overrun = (state_q == StSend) && !(accept && last);
    end else if (accept) begin
      if (last) begin
        state_d = StIdle;
        chan_d  = '0;
      end else begin
        chan_d = chan_q + 4'd1;
      end
    end
  end

  assign pcm.out_valid   = (state_q == StSend);
  assign pcm.out_channel = chan_q;
  assign pcm.out_data    = frame_q[chan_q];
  assign pcm.out_sop     = (state_q == StSend) && (chan_q == 4'd0);
  assign pcm.out_eop     = (state_q == StSend) && last;

`ifdef PDM_CIC_OVERRUN_CNT_EN
  logic [15:0] ovr_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovr_cnt_q <= '0;
    end else if (overrun && (ovr_cnt_q != 16'hFFFF)) begin
      ovr_cnt_q <= ovr_cnt_q + 16'd1;
    end
  end

  assign overrun_count = ovr_cnt_q;
`endif
endmodule
